// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register fed by four requesters.
// Each requester gets one grant, one commit, one ack, then must drop its request before it can be granted again.
module dff_bank_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   wdata,
  input  logic                 clr,
  output logic [3:0]           grant,
  output logic [3:0]           ack,
  output logic [WIDTH-1:0]     q,
  output logic                 busy
);

  localparam int unsigned NREQ = 4;

  typedef enum logic [1:0] {IDLE, GRANT, DONE, RELEASE} state_t;

  state_t           state;
  logic [1:0]       lw;
  logic [1:0]       w;
  logic [1:0]       pick_c;
  logic             any_req_c;
  logic [WIDTH-1:0] lanes [NREQ];

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Split the packed write data into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lanes[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority: scan from the offset farthest from lw down to the nearest, so the nearest set bit after lw wins.
  always_comb begin
    pick_c    = lw;
    any_req_c = |req;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[lw + 2'(k)]) begin
        pick_c = lw + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lw    <= 2'd3;
      w     <= 2'd0;
      grant <= '0;
      ack   <= '0;
      q     <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            q <= '0;
          end else if (any_req_c) begin
            w     <= pick_c;
            grant <= onehot(pick_c);
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        // The commit does not depend on req[w] still being high.
        GRANT: begin
          q     <= lanes[w];
          lw    <= w;
          grant <= '0;
          ack   <= onehot(w);
          state <= DONE;
        end
        DONE: begin
          ack <= '0;
          if (req[w]) begin
            state <= RELEASE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RELEASE: begin
          if (!req[w]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed table-driven bench for dff_bank_arbiter: one vector per clock cycle,
// plus a hand-written sequence for an asynchronous reset between edges.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        clr;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  dff_bank_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .clr   (clr),
    .grant (grant),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [3:0]  g;
    logic [3:0]  a;
    logic [7:0]  q;
    logic        b;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rst, input logic c, input logic [3:0] r,
                              input logic [31:0] wd, input logic [3:0] g,
                              input logic [3:0] a, input logic [7:0] qq, input logic b);
    vec_t v;
    v.rst = rst; v.clr = c; v.req = r; v.wd = wd;
    v.g = g; v.a = a; v.q = qq; v.b = b;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [3:0] g, input logic [3:0] a,
                           input logic [7:0] qq, input logic b);
    check("grant", idx, 8'(grant), 8'(g));
    check("ack",   idx, 8'(ack),   8'(a));
    check("q",     idx, q,         qq);
    check("busy",  idx, 8'(busy),  8'(b));
  endtask

  localparam logic [31:0] WD_RST = 32'h131211A5;
  localparam logic [31:0] WD_SW  = 32'h003C0000;
  localparam logic [31:0] WD_RR  = 32'h13121110;
  localparam logic [31:0] WD_FF  = 32'h000000FF;
  localparam logic [31:0] WD_5A  = 32'h0000005A;

  initial begin
    reset = 1'b0;
    req   = 4'b1111;
    wdata = WD_RST;
    clr   = 1'b0;

    // Reset held with all requests, then released
    tv.push_back(mk(0, 0, 4'b1111, WD_RST, 4'b0000, 4'b0000, 8'h00, 0));
    tv.push_back(mk(0, 0, 4'b1111, WD_RST, 4'b0000, 4'b0000, 8'h00, 0));
    tv.push_back(mk(1, 0, 4'b1111, WD_RST, 4'b0001, 4'b0000, 8'h00, 1));
    tv.push_back(mk(1, 0, 4'b1111, WD_RST, 4'b0000, 4'b0001, 8'hA5, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_RST, 4'b0000, 4'b0000, 8'hA5, 0));
    // Single write from requester 2, dropped on seeing grant
    tv.push_back(mk(1, 0, 4'b0100, WD_SW, 4'b0100, 4'b0000, 8'hA5, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_SW, 4'b0000, 4'b0100, 8'h3C, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_SW, 4'b0000, 4'b0000, 8'h3C, 0));
    // Reset to restore lw=3, then round robin 0,1,2,3
    tv.push_back(mk(0, 0, 4'b0000, WD_RR, 4'b0000, 4'b0000, 8'h00, 0));
    tv.push_back(mk(1, 0, 4'b1111, WD_RR, 4'b0001, 4'b0000, 8'h00, 1));
    tv.push_back(mk(1, 0, 4'b1111, WD_RR, 4'b0000, 4'b0001, 8'h10, 1));
    tv.push_back(mk(1, 0, 4'b1110, WD_RR, 4'b0000, 4'b0000, 8'h10, 0));
    tv.push_back(mk(1, 0, 4'b1110, WD_RR, 4'b0010, 4'b0000, 8'h10, 1));
    tv.push_back(mk(1, 0, 4'b1110, WD_RR, 4'b0000, 4'b0010, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1100, WD_RR, 4'b0000, 4'b0000, 8'h11, 0));
    tv.push_back(mk(1, 0, 4'b1100, WD_RR, 4'b0100, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1100, WD_RR, 4'b0000, 4'b0100, 8'h12, 1));
    tv.push_back(mk(1, 0, 4'b1000, WD_RR, 4'b0000, 4'b0000, 8'h12, 0));
    tv.push_back(mk(1, 0, 4'b1000, WD_RR, 4'b1000, 4'b0000, 8'h12, 1));
    tv.push_back(mk(1, 0, 4'b1000, WD_RR, 4'b0000, 4'b1000, 8'h13, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_RR, 4'b0000, 4'b0000, 8'h13, 0));
    tv.push_back(mk(1, 0, 4'b0001, WD_RR, 4'b0001, 4'b0000, 8'h13, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_RR, 4'b0000, 4'b0001, 8'h10, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_RR, 4'b0000, 4'b0000, 8'h10, 0));
    // Requester 1 holds through RELEASE while requester 3 waits
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0010, 4'b0000, 8'h10, 1));
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0000, 4'b0010, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0000, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0000, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0000, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0000, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1010, WD_RR, 4'b0000, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b1000, WD_RR, 4'b0000, 4'b0000, 8'h11, 0));
    tv.push_back(mk(1, 0, 4'b1000, WD_RR, 4'b1000, 4'b0000, 8'h11, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_RR, 4'b0000, 4'b1000, 8'h13, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_RR, 4'b0000, 4'b0000, 8'h13, 0));
    // Load 8'hFF, clear in IDLE beats a pending request, then clr ignored in GRANT
    tv.push_back(mk(1, 0, 4'b0001, WD_FF, 4'b0001, 4'b0000, 8'h13, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_FF, 4'b0000, 4'b0001, 8'hFF, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_FF, 4'b0000, 4'b0000, 8'hFF, 0));
    tv.push_back(mk(1, 1, 4'b0001, WD_FF, 4'b0000, 4'b0000, 8'h00, 0));
    tv.push_back(mk(1, 0, 4'b0001, WD_FF, 4'b0001, 4'b0000, 8'h00, 1));
    tv.push_back(mk(1, 1, 4'b0000, WD_5A, 4'b0000, 4'b0001, 8'h5A, 1));
    tv.push_back(mk(1, 0, 4'b0000, WD_5A, 4'b0000, 4'b0000, 8'h5A, 0));

    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst;
      clr   = tv[i].clr;
      req   = tv[i].req;
      wdata = tv[i].wd;
      @(posedge clk);
      #1;
      check_all(i, tv[i].g, tv[i].a, tv[i].q, tv[i].b);
    end

    // Asynchronous reset between edges while requester 1 is granted
    clr   = 1'b0;
    req   = 4'b0010;
    wdata = 32'h00007700;
    @(posedge clk);
    #1;
    check_all(100, 4'b0010, 4'b0000, 8'h5A, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all(101, 4'b0000, 4'b0000, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_all(102, 4'b0000, 4'b0000, 8'h00, 1'b0);
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    check_all(103, 4'b0000, 4'b0000, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_all(104, 4'b0000, 4'b0000, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

- Round-robin write arbiter for a shared WIDTH-bit D flip-flop register.
- Up to four requesters each present data and a request. The arbiter grants one requester at a time and commits its data into the shared register. It then acknowledges and waits for the request to be released.
- Sits between the requesting datapath blocks and the shared state register; the register is the only storage written through it.

## Interface
- WIDTH, 8, width of the shared register and each requester's write data
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  4  write request per requester; bit i belongs to requester i
- wdata  in  4*WIDTH  packed write data; requester i drives bits [i*WIDTH +: WIDTH]
- clr  in  1  synchronous clear request for the shared register
- grant  out  4  one-hot grant, registered
- ack  out  4  one-hot write-done pulse, registered
- q  out  WIDTH  shared register contents
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- States: IDLE, GRANT, DONE, RELEASE. All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=0, ack=0, q=0, busy=0.
  - last-winner pointer lw=3, so requester 0 has top priority after reset.
- IDLE:
  - If clr=1: q<=0 and stay in IDLE. clr has priority over req.
  - Else if any req: winner w = first set bit scanning lw+1, lw+2, lw+3, lw (mod 4). Then grant<=onehot(w), go to GRANT.
  - Else stay in IDLE.
- GRANT (exactly one cycle), at the next edge:
  - q<=wdata[w] and lw<=w.
  - grant<=0, ack<=onehot(w), go to DONE.
  - The write commits even if req[w] dropped during GRANT.
  - clr is ignored in GRANT.
- DONE (one cycle), at the next edge:
  - ack<=0.
  - If req[w]=1, go to RELEASE; else go to IDLE.
- RELEASE:
  - Stay while req[w]=1; go to IDLE on the edge where req[w]=0.
  - A held request is never re-granted without first dropping.
- clr is honoured only in IDLE. clr asserted in GRANT, DONE or RELEASE is ignored; it is not queued.
- Requests from other requesters are not latched. They are arbitrated fresh at the next IDLE.
- Multiple simultaneous requests: each gets one write per turn, in rotating order starting after lw.
- grant and ack are never both nonzero. Neither ever has more than one bit set.

## Timing
- Request sampled at edge k in IDLE: grant high after edge k, q and ack updated after edge k+1, ack low after edge k+2.
- Write latency: 2 edges from request sample to q update.
- Maximum throughput: one write per 3 cycles, when the winner drops req while in GRANT or DONE.
- If the winner holds req through DONE, each extra cycle spent in RELEASE adds one cycle before the next arbitration.
- Reset mid-transaction (any state) aborts immediately:
  - q=0, lw=3, grant=0, ack=0.
  - A write pending in GRANT is discarded.
- After reset deasserts: first arbitration happens at the first rising edge with reset=1.
- busy: rises with grant (after edge k); falls on the edge entering IDLE.

## Test plan
- Reset/defaults: reset=0 with req=4'b1111 → grant=0, ack=0, q=0, busy=0 throughout. Release reset with req=4'b1111 and wdata[0]=8'hA5 → grant=4'b0001, then q=8'hA5 and ack=4'b0001.
- Single write:
  - Stimulus: req=4'b0100, wdata[2]=8'h3C, req dropped on seeing grant.
  - Required: grant=4'b0100 for 1 cycle; then q=8'h3C with ack=4'b0100 for 1 cycle; IDLE after 3 cycles total.
- Round robin:
  - Stimulus: req=4'b1111 held, each requester dropping after its ack; wdata = 8'h10, 8'h11, 8'h12, 8'h13 for requesters 0-3.
  - Required: grants in order 0,1,2,3; q sequence 8'h10, 8'h11, 8'h12, 8'h13.
  - Then requester 0 requests again → granted next.
- Hold/release:
  - Stimulus: requester 1 holds req for 5 cycles after ack; requester 3 is requesting meanwhile.
  - Required: FSM stays in RELEASE and grant stays 0; requester 1 is not re-granted; grant=4'b1000 only after req[1] falls.
- Clear:
  - clr=1 in IDLE with req=4'b0001 and q=8'hFF → q=8'h00 and no grant that cycle; grant=4'b0001 on the following edge.
  - clr=1 during GRANT → ignored; q takes the granted data.
- Async reset mid-GRANT: reset=0 between edges while grant=4'b0010 → grant, ack and q go to 0 without waiting for a clock edge; requester 1's data is never written.
